cmd_packetizer: RTL
===================

CMD_PACKETIZER -- requirements
Module: cmd_packetizer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: system clock; all logic is rising-edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port req_valid, input, 1 bit: a command request is presented.
REQ-004 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-005 The block SHALL have port req_opcode, input, 8 bits: command opcode (0x01 CLEAR, 0x02 RASTER, 0x03 SIMD, 0x10 SET_COLOR, 0x11 SET_VIEWPORT; others passed through unchanged).
REQ-006 The block SHALL have port req_len, input, 16 bits: payload word count.
REQ-007 The block SHALL have port req_payload, input, 192 bits: payload words; word i = bits [32*i+31:32*i], i = 0..5.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: stream word valid.
REQ-009 The block SHALL have port cmd_data, output, 32 bits: stream word.
REQ-010 The block SHALL have port cmd_ready, input, 1 bit: downstream accepts the word.
REQ-011 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when the last word of a command is accepted.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-014 The block SHALL have port cmd_count, output, 16 bits: number of commands fully sent.

Function
REQ-015 The FSM SHALL have the states IDLE, HEADER and PAYLOAD; req_ready SHALL be 1 only in IDLE.
REQ-016 On a request handshake (req_valid && req_ready) the block SHALL register req_opcode, req_len and req_payload.
- Later changes on the req_* inputs SHALL NOT affect the command in flight.
REQ-017 If the accepted req_len > 6, the block SHALL pulse err in the next cycle, stay in IDLE and emit no stream words.
REQ-018 If the accepted req_len <= 6, the next state SHALL be HEADER, and cmd_valid SHALL rise one cycle after the handshake.
REQ-019 The header word SHALL be cmd_data = {opcode[7:0], 8'h00, len[15:0]}.
REQ-020 In HEADER, when cmd_ready is 1:
- if len == 0: go to IDLE, pulse done, increment cmd_count;
- otherwise: go to PAYLOAD with index = 0.
REQ-021 In PAYLOAD, cmd_data SHALL be payload word[index]; when cmd_ready is 1:
- if index == len-1: go to IDLE, pulse done, increment cmd_count;
- otherwise: increment index.
REQ-022 cmd_valid and cmd_data SHALL be registered outputs.
- cmd_valid SHALL stay high, with cmd_data stable, until a cycle in which cmd_ready is 1.
- cmd_valid SHALL NOT depend combinationally on cmd_ready.
REQ-023 cmd_valid SHALL be 0 in IDLE. The stream SHALL have no gaps inside a command: with cmd_ready held at 1, a command of N payload words SHALL occupy N+1 consecutive cycles.
REQ-024 Between commands there SHALL be at least one IDLE cycle, so the minimum request-to-request spacing is len+2 cycles.
REQ-025 done and err SHALL be one-cycle pulses and SHALL never be asserted in the same cycle.
REQ-026 cmd_count SHALL wrap from 0xFFFF to 0x0000; rejected requests SHALL NOT increment it.
REQ-027 The index register SHALL be 3 bits, and the block SHALL never read a payload word at index >= len.
REQ-028 (Simulation-only checks) While cmd_valid is 1 and cmd_ready is 0, cmd_data SHALL NOT change; req_ready and cmd_valid SHALL never be 1 together.

Reset
REQ-029 While rst_n = 0 the block SHALL drive:
- state = IDLE, req_ready = 0, cmd_valid = 0, cmd_data = 0;
- busy = 0, done = 0, err = 0, cmd_count = 0, index = 0.
REQ-030 req_ready SHALL go to 1 in the first clock cycle after rst_n deasserts.
REQ-031 Reset asserted mid-command SHALL abort the command immediately.
- cmd_valid SHALL drop asynchronously.
- No done pulse SHALL be produced.
- The remaining words SHALL be discarded.

Verification
REQ-032 Bench SHALL cover SET_COLOR: opcode 0x10, len 1, word0 0xFF00FF00, cmd_ready held 1 -> stream 0x10000001, 0xFF00FF00 in consecutive cycles; done pulse; cmd_count = 1.
REQ-033 Bench SHALL cover CLEAR: opcode 0x01, len 0 -> single word 0x01000000; done in the cycle it is accepted.
REQ-034 Bench SHALL cover RASTER under backpressure: opcode 0x02, len 6, words 10, 20, 30, 40, 50, 60, cmd_ready toggling 1-0-0-1 pseudo-randomly -> stream 0x02000006, then 10..60 in order; data stable during stalls; exactly 7 handshakes.
REQ-035 Bench SHALL cover rejection: opcode 0x03, len 7 -> err pulse one cycle after the handshake; cmd_valid stays 0; cmd_count unchanged; the next valid request is accepted normally.
REQ-036 Bench SHALL cover reset during a transfer: rst_n low after the 2nd payload word of a len-4 command -> cmd_valid = 0 immediately, no done pulse, cmd_count = 0; a fresh len-1 command afterwards streams correctly.
REQ-037 Bench SHALL cover counter wrap: cmd_count forced to 0xFFFF by sending 65535 len-0 commands (or with a fast-forward hook), plus one more command -> cmd_count = 0x0000.

Source files
------------

// File: rtl/cmd_packetizer_if.sv
// rtl/cmd_packetizer_if.sv - request and command-stream signal bundle for cmd_packetizer
interface cmd_packetizer_if;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_opcode;
  logic [15:0]  req_len;
  logic [191:0] req_payload;
  logic         cmd_valid;
  logic [31:0]  cmd_data;
  logic         cmd_ready;

  // packetizer side: consumes requests, produces the command stream
  modport master (
    input  req_valid, req_opcode, req_len, req_payload, cmd_ready,
    output req_ready, cmd_valid, cmd_data
  );

  // environment side: issues requests, sinks the command stream
  modport slave (
    output req_valid, req_opcode, req_len, req_payload, cmd_ready,
    input  req_ready, cmd_valid, cmd_data
  );
endinterface

// File: rtl/cmd_packetizer.sv
// rtl/cmd_packetizer.sv - turns one command request into a header word plus up to six payload words
module cmd_packetizer (
  input  logic             clk,
  input  logic             rst_n,
  cmd_packetizer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      cmd_count
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] HEADER  = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;

  logic [1:0]   state;
  logic [15:0]  len_q;
  logic [191:0] payload_q;
  logic [2:0]   idx_q;
  logic         valid_q;
  logic [31:0]  data_q;
  logic         done_q;
  logic         err_q;
  logic [15:0]  cnt_q;
  logic         last_word;

  // Explicit word mux so indices 6 and 7 can never address beyond the payload.
  function automatic logic [31:0] word_at(input logic [191:0] p, input logic [2:0] i);
    case (i)
      3'd0:    word_at = p[31:0];
      3'd1:    word_at = p[63:32];
      3'd2:    word_at = p[95:64];
      3'd3:    word_at = p[127:96];
      3'd4:    word_at = p[159:128];
      3'd5:    word_at = p[191:160];
      default: word_at = 32'h0;
    endcase
  endfunction

  assign last_word     = ({13'd0, idx_q} == (len_q - 16'd1));
  // ready is gated by rst_n so it reads 0 throughout reset
  assign bus.req_ready = rst_n && (state == IDLE);
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_data  = data_q;
  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign cmd_count     = cnt_q;

  // Request capture, header/payload sequencing and completion bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= 16'd0;
      payload_q <= 192'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      data_q    <= 32'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            len_q     <= bus.req_len;
            payload_q <= bus.req_payload;
            idx_q     <= 3'd0;
            if (bus.req_len > 16'd6) begin
              err_q <= 1'b1;
            end else begin
              state   <= HEADER;
              valid_q <= 1'b1;
              data_q  <= {bus.req_opcode, 8'h00, bus.req_len};
            end
          end
        end
        HEADER: begin
          if (bus.cmd_ready) begin
            if (len_q == 16'd0) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              cnt_q   <= cnt_q + 16'd1;
            end else begin
              state  <= PAYLOAD;
              idx_q  <= 3'd0;
              data_q <= word_at(payload_q, 3'd0);
            end
          end
        end
        PAYLOAD: begin
          if (bus.cmd_ready) begin
            if (last_word) begin
              state   <= IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= 3'd0;
              cnt_q   <= cnt_q + 16'd1;
            end else begin
              idx_q  <= idx_q + 3'd1;
              data_q <= word_at(payload_q, idx_q + 3'd1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // A stalled word must be held until it is taken.
  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.cmd_valid && !bus.cmd_ready) |=> $stable(bus.cmd_data));
  // Request acceptance and streaming are mutually exclusive.
  a_ready_valid_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.req_ready && bus.cmd_valid));
  // Completion and rejection never coincide.
  a_done_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done && err));

endmodule
